// File: rtl/seq_mem_copy_pkg.sv
// Shared types and sizes for the register-file copy/fill engine.
// Latency: n/a (declarations only); backpressure: n/a.
package seq_mem_copy_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COPY  = 3'd1,
      DRAIN = 3'd2,
      FILL  = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef enum logic {
      OP_COPY = 1'b0,
      OP_FILL = 1'b1
   } op_t;

   localparam int AW     = 3;
   localparam int DW     = 8;
   localparam int MAXLEN = 8;

endpackage

// File: rtl/seq_mem_copy_addr_gen.sv
// Loadable 3-bit address counter that wraps 7 -> 0; load has priority over increment.
// Latency: one cycle from load/inc to o_addr; no backpressure.
module seq_mem_copy_addr_gen
   import seq_mem_copy_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_load,
   input  logic [AW-1:0] i_load_val,
   input  logic          i_inc,
   output logic [AW-1:0] o_addr
);

   logic [AW-1:0] r_addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr <= '0;
      end else if (i_load) begin
         r_addr <= i_load_val;
      end else if (i_inc) begin
         r_addr <= r_addr + AW'(1);
      end
   end

   assign o_addr = r_addr;

endmodule

// File: rtl/seq_mem_8x8b_copy_engine.sv
// Ascending block COPY/FILL master for an 8x8 1r1w register file with write forwarding.
// Latency: COPY N+2 cycles, FILL N+1, len=0 one cycle to done; start is only taken in IDLE.
module seq_mem_8x8b_copy_engine #(
   parameter int NENTRIES = 8,
   parameter int DW       = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          op,
   input  logic [2:0]    src_addr,
   input  logic [2:0]    dst_addr,
   input  logic [3:0]    len,
   input  logic [DW-1:0] fill_value,
   output logic          busy,
   output logic          done,
   output logic [2:0]    rf_read_addr,
   input  logic [DW-1:0] rf_read_data,
   output logic          rf_write_en,
   output logic [2:0]    rf_write_addr,
   output logic [DW-1:0] rf_write_data
);
   import seq_mem_copy_pkg::*;

   localparam logic [3:0] LEN_MAX = 4'(NENTRIES);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_cnt;
   logic [3:0]    r_len;
   logic [DW-1:0] r_fill;
   logic [DW-1:0] r_data;
   logic [3:0]    w_len_clamp;
   logic          w_load;
   logic          w_src_inc;
   logic          w_dst_inc;
   logic          w_last;
   logic [AW-1:0] w_src_addr;
   logic [AW-1:0] w_dst_addr;

   assign w_len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
   assign w_last      = ((r_cnt + 4'd1) == r_len);

   seq_mem_copy_addr_gen u_src_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_load),
      .i_load_val (src_addr),
      .i_inc      (w_src_inc),
      .o_addr     (w_src_addr)
   );

   seq_mem_copy_addr_gen u_dst_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_load),
      .i_load_val (dst_addr),
      .i_inc      (w_dst_inc),
      .o_addr     (w_dst_addr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_len   <= '0;
         r_fill  <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_cnt  <= '0;
            r_len  <= w_len_clamp;
            r_fill <= fill_value;
         end else if (r_state == COPY || r_state == FILL) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if (r_state == COPY) begin
            r_data <= rf_read_data;
         end
      end
   end

   // COPY writes lag reads by one cycle; the register file forwards the
   // same-cycle write so an overlapping read still sees element k-1.
   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_src_inc     = 1'b0;
      w_dst_inc     = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      rf_read_addr  = '0;
      rf_write_en   = 1'b0;
      rf_write_addr = '0;
      rf_write_data = '0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load = 1'b1;
               if (w_len_clamp == 4'd0) begin
                  w_state_nxt = DONE;
               end else if (op_t'(op) == OP_FILL) begin
                  w_state_nxt = FILL;
               end else begin
                  w_state_nxt = COPY;
               end
            end
         end
         COPY: begin
            busy         = 1'b1;
            rf_read_addr = w_src_addr;
            w_src_inc    = 1'b1;
            if (r_cnt != 4'd0) begin
               rf_write_en   = 1'b1;
               rf_write_addr = w_dst_addr;
               rf_write_data = r_data;
               w_dst_inc     = 1'b1;
            end
            if (w_last) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy          = 1'b1;
            rf_write_en   = 1'b1;
            rf_write_addr = w_dst_addr;
            rf_write_data = r_data;
            w_state_nxt   = DONE;
         end
         FILL: begin
            busy          = 1'b1;
            rf_write_en   = 1'b1;
            rf_write_addr = w_dst_addr;
            rf_write_data = r_fill;
            w_dst_inc     = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_mem_8x8b_copy_engine.sv
// Bench for the copy/fill engine with a behavioural forwarding register file.
// Vector table plus hand sequences for overlap, busy-start, back-to-back and reset.
module tb_seq_mem_8x8b_copy_engine;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       op;
   logic [2:0] src_addr;
   logic [2:0] dst_addr;
   logic [3:0] len;
   logic [7:0] fill_value;
   logic       busy;
   logic       done;
   logic [2:0] rf_read_addr;
   logic [7:0] rf_read_data;
   logic       rf_write_en;
   logic [2:0] rf_write_addr;
   logic [7:0] rf_write_data;

   logic [7:0]  rf_mem [8];
   logic        rf_load;
   logic [63:0] rf_img;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_mem_8x8b_copy_engine #(.NENTRIES(8), .DW(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .op            (op),
      .src_addr      (src_addr),
      .dst_addr      (dst_addr),
      .len           (len),
      .fill_value    (fill_value),
      .busy          (busy),
      .done          (done),
      .rf_read_addr  (rf_read_addr),
      .rf_read_data  (rf_read_data),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data)
   );

   // Register file model: write on posedge, combinational read with same-cycle forwarding.
   always @(posedge clk) begin
      if (rf_load) begin
         for (int i = 0; i < 8; i++) rf_mem[i] <= rf_img[8*i +: 8];
      end else if (rf_write_en) begin
         rf_mem[rf_write_addr] <= rf_write_data;
      end
   end
   assign rf_read_data = (rf_write_en && rf_write_addr == rf_read_addr) ?
                         rf_write_data : rf_mem[rf_read_addr];

   function automatic logic [63:0] mem_image();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = rf_mem[i];
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic preload(input logic [63:0] img);
      @(negedge clk);
      rf_img  = img;
      rf_load = 1'b1;
      @(negedge clk);
      rf_load = 1'b0;
   endtask

   // Launch at the next edge, then sample each cycle at negedge until done.
   task automatic run_cmd(input logic o, input logic [2:0] s, input logic [2:0] d,
                          input logic [3:0] l, input logic [7:0] f,
                          output int done_cyc, output int nwr,
                          output int bad_wa, output int bad_busy);
      logic [2:0] ea;
      done_cyc = -1; nwr = 0; bad_wa = 0; bad_busy = 0;
      @(negedge clk);
      op = o; src_addr = s; dst_addr = d; len = l; fill_value = f; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = ~o; src_addr = ~s; dst_addr = ~d; len = 4'hF; fill_value = ~f;
      for (int c = 1; c <= 30; c++) begin
         if (rf_write_en) begin
            ea = d + 3'(nwr);
            if (rf_write_addr !== ea) bad_wa++;
            nwr++;
         end
         if (done) begin
            done_cyc = c;
            if (busy) bad_busy++;
            break;
         end else if (!busy) begin
            bad_busy++;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      string       name;
      logic        op;
      logic [2:0]  src;
      logic [2:0]  dst;
      logic [3:0]  len;
      logic [7:0]  fill;
      logic [63:0] pre;
      logic [63:0] exp_mem;
      int          exp_wr;
      int          exp_done;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic o, input logic [2:0] s,
                               input logic [2:0] d, input logic [3:0] l, input logic [7:0] f,
                               input logic [63:0] p, input logic [63:0] m,
                               input int w, input int dn);
      vec_t v;
      v.name = nm; v.op = o; v.src = s; v.dst = d; v.len = l; v.fill = f;
      v.pre = p; v.exp_mem = m; v.exp_wr = w; v.exp_done = dn;
      return v;
   endfunction

   localparam logic [63:0] PRE_10 = 64'h17161514_13121110;
   localparam logic [63:0] PRE_ID = 64'h07060504_03020100;

   vec_t vecs [8];
   int   dc, nw, bw, bb, ndone, first_done;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk("copy_0_to_4",   1'b0, 3'd0, 3'd4, 4'd4,  8'h00, PRE_10, 64'h13121110_13121110, 4, 6);
      vecs[1] = mk("fill_wrap",     1'b1, 3'd0, 3'd6, 4'd4,  8'hA5, PRE_10, 64'hA5A51514_1312A5A5, 4, 5);
      vecs[2] = mk("copy_fwd_ovl",  1'b0, 3'd0, 3'd1, 4'd4,  8'h00, PRE_ID, 64'h07060500_00000000, 4, 6);
      vecs[3] = mk("copy_back_ovl", 1'b0, 3'd1, 3'd0, 4'd4,  8'h00, PRE_ID, 64'h07060504_04030201, 4, 6);
      vecs[4] = mk("len0",          1'b0, 3'd2, 3'd5, 4'd0,  8'h00, PRE_10, PRE_10,                0, 1);
      vecs[5] = mk("len12_self",    1'b0, 3'd3, 3'd3, 4'd12, 8'h00, PRE_10, PRE_10,                8, 10);
      vecs[6] = mk("fill_len12",    1'b1, 3'd5, 3'd0, 4'd12, 8'h5A, PRE_10, 64'h5A5A5A5A_5A5A5A5A, 8, 9);
      vecs[7] = mk("copy_src_wrap", 1'b0, 3'd7, 3'd2, 4'd3,  8'h00, PRE_10, 64'h17161511_10171110, 3, 5);

      reset_n = 1'b0; start = 1'b0; op = 1'b0; src_addr = 3'd5; dst_addr = 3'd6;
      len = 4'd3; fill_value = 8'hFF; rf_load = 1'b0; rf_img = '0;
      #22;
      check("reset_outputs", 64'({busy, done, rf_write_en, rf_write_addr, rf_write_data, rf_read_addr}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         preload(vecs[i].pre);
         run_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill, dc, nw, bw, bb);
         check({vecs[i].name, "_done_cycle"}, 64'(dc), 64'(vecs[i].exp_done));
         check({vecs[i].name, "_writes"},     64'(nw), 64'(vecs[i].exp_wr));
         check({vecs[i].name, "_bad_waddr"},  64'(bw), 64'd0);
         check({vecs[i].name, "_bad_busy"},   64'(bb), 64'd0);
         @(negedge clk);
         check({vecs[i].name, "_mem"}, mem_image(), vecs[i].exp_mem);
      end

      // start pulsed while busy must be ignored; exactly one done
      preload(PRE_10);
      @(negedge clk);
      op = 1'b1; dst_addr = 3'd0; len = 4'd4; fill_value = 8'h77; start = 1'b1;
      @(posedge clk);
      ndone = 0; first_done = -1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start = (c == 2);
         if (c == 2) begin op = 1'b0; src_addr = 3'd4; len = 4'd8; end
         if (done) begin
            ndone++;
            if (first_done < 0) first_done = c;
         end
      end
      check("busy_start_ndone",    64'(ndone), 64'd1);
      check("busy_start_done_cyc", 64'(first_done), 64'd5);
      check("busy_start_mem",      mem_image(), 64'h17161514_77777777);

      // back-to-back: start in DONE ignored, start in following IDLE accepted
      @(negedge clk);
      op = 1'b1; dst_addr = 3'd0; len = 4'd1; fill_value = 8'h33; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("b2b_done_c2", 64'(done), 64'd1);
      dst_addr = 3'd1; fill_value = 8'h44; start = 1'b1;
      @(negedge clk);
      check("b2b_idle_c3", 64'({busy, done, rf_write_en}), 64'd0);
      @(negedge clk);
      start = 1'b0;
      check("b2b_fill_c4", 64'({busy, rf_write_en, rf_write_addr, rf_write_data}), 64'({1'b1, 1'b1, 3'd1, 8'h44}));
      @(negedge clk);
      check("b2b_done_c5", 64'(done), 64'd1);
      @(negedge clk);
      check("b2b_mem", mem_image(), 64'h17161514_77774433);

      // reset mid-COPY after two committed writes
      preload(PRE_10);
      @(negedge clk);
      op = 1'b0; src_addr = 3'd0; dst_addr = 3'd4; len = 4'd4; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("midreset_outputs", 64'({busy, done, rf_write_en, rf_write_addr, rf_write_data, rf_read_addr}), 64'd0);
      ndone = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("midreset_no_done", 64'(ndone), 64'd0);
      check("midreset_mem", mem_image(), 64'h17161110_13121110);
      run_cmd(1'b0, 3'd0, 3'd6, 4'd2, 8'h00, dc, nw, bw, bb);
      check("post_reset_done_cycle", 64'(dc), 64'd4);
      check("post_reset_writes",     64'(nw), 64'd2);
      @(negedge clk);
      check("post_reset_mem", mem_image(), 64'h11101110_13121110);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_mem_8x8b_copy_engine.md
Name: seq_mem_8x8b_copy_engine

Overview:
- Master that drives the read and write ports of an 8-entry x 8-bit 1r1w register file with same-cycle write-to-read forwarding.
- Performs block COPY (src to dst, ascending, addresses wrap mod 8) or FILL (constant to dst) of up to 8 entries.
- Launched by a start pulse. Reports busy and a one-cycle done pulse.
- Sits between a control/CSR block and the register file.

Parameters:
- NENTRIES, 8, register file depth. The block is fixed at 8; the parameter is informational and addresses are 3 bits.
- DW, 8, data width.

Ports:
- clk  in  1  clock; all state updates on the posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  1  0 = OP_COPY, 1 = OP_FILL.
- src_addr  in  3  first source entry (COPY only).
- dst_addr  in  3  first destination entry.
- len  in  4  entry count, 0..8; values above 8 are clamped to 8.
- fill_value  in  8  constant written by FILL.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- rf_read_addr  out  3  to the register file read_addr.
- rf_read_data  in  8  from the register file read_data; combinational, with forwarding.
- rf_write_en  out  1  to the register file write_en.
- rf_write_addr  out  3  to the register file write_addr.
- rf_write_data  out  8  to the register file write_data.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; all counters and the data register clear.
  - Outputs immediately become busy=0, done=0, rf_write_en=0, and rf_read_addr, rf_write_addr and rf_write_data all 0.
  - A reset mid-operation abandons the operation: no done pulse, and writes already committed stay in the register file.
- Command latch:
  - In IDLE, start=1 at edge E0 latches op, src_addr, dst_addr, clamped len and fill_value.
  - start is ignored while not in IDLE; inputs may change freely after E0.
- States: IDLE, COPY, DRAIN, FILL, DONE.
- len=0: IDLE goes to DONE after E0. No register file access; done=1 for one cycle, busy=0.
- COPY with N entries (k counts from 0):
  - Cycles 1..N (state COPY): rf_read_addr = src+k.
  - Each edge captures rf_read_data into data_q.
  - Cycles 2..N: also drive rf_write_en=1, rf_write_addr = dst+k-1, rf_write_data = data_q.
  - Cycle N+1 (state DRAIN): write dst+N-1 only; rf_read_addr=0.
  - Cycle N+2: DONE.
- FILL with N entries:
  - Cycles 1..N (state FILL): rf_write_en=1, rf_write_addr = dst+k, rf_write_data = fill_value.
  - Cycle N+1: DONE.
- DONE: lasts one cycle with done=1, busy=0. Returns to IDLE; a new start is accepted in IDLE only.
- busy=1 exactly in COPY, DRAIN and FILL.
- Outside write cycles: rf_write_en=0 and rf_write_addr, rf_write_data are 0. Outside COPY: rf_read_addr=0.
- Address arithmetic is 3-bit and wraps 7 to 0. The counter is 4 bits and compares against the clamped len.
- Overlap semantics:
  - The result equals a sequential ascending element-by-element copy: element k observes all writes of elements < k.
  - The one-cycle write lag is covered by the register file forwarding the same-cycle write.
  - The engine does no hazard detection of its own.
- src==dst COPY is legal: it rewrites the same values.

Decomposition:
- Package seq_mem_copy_pkg holds:
  - state_t enum {IDLE, COPY, DRAIN, FILL, DONE};
  - op_t enum {OP_COPY=1'b0, OP_FILL=1'b1};
  - localparams AW=3, DW=8, MAXLEN=8.
- Sub-module seq_mem_copy_addr_gen: loadable 3-bit wrapping address counter. It is instantiated twice (src and dst).
- The register file itself is instantiated only by the testbench, wired to the rf_* ports.

Test Plan:
- RF preloaded mem[i]=i+0x10. COPY src=0 dst=4 len=4:
  - writes 4..7 in cycles 2..5; done in cycle 6;
  - final mem = 10,11,12,13,10,11,12,13.
- FILL dst=6 len=4 fill=0xA5 -> writes to 6,7,0,1 (wrap); done in cycle 5; other entries unchanged.
- Forward overlap: mem[i]=i. COPY src=0 dst=1 len=4 -> mem[1..4] all 0x00, proving forwarding is used. Then COPY src=1 dst=0 len=4 on fresh mem -> mem[0..3]=1,2,3,4.
- len=0 and len=12 (clamped to 8):
  - len=0 -> done in cycle 1 with no write;
  - len=12 COPY src=3 dst=3 -> 8 writes, done in cycle 10, contents unchanged.
- start pulsed while busy -> ignored; exactly one done. Back-to-back: start in the DONE cycle is ignored, start the next cycle is accepted.
- reset_n low mid-COPY (after 2 writes) -> all outputs 0 immediately; first 2 writes persist; no done; a new command after release works.
